stft_bin_read_arbiter: RTL and testbench
========================================

// Module: stft_bin_read_arbiter
// PURPOSE
//  Shares the read port of the STFT spectrum RAM (FFT_RAM, 2*WORD_WIDTH, sync read, 1-cycle latency)
//  between the sliding-DFT sweep and a display-side burst reader. The sweep has absolute priority and
//  sees zero added latency. Display bursts (start bin, length) are streamed out in the idle gaps
//  between sweeps, pausing whenever a sweep is active, with no dropped or duplicated bins.
// PARAMETERS
//  WORD_WIDTH  16   width of one real/imag component; bin word is 2*WORD_WIDTH
//  FFT_SIZE    256  number of bins (power of 2); AW = $clog2(FFT_SIZE)
// PORTS
//  clk             in   1        system clock (27 MHz)
//  reset           in   1        asynchronous, active-low reset
//  sweep_active    in   1        high while the DFT sweep owns the RAM read port
//  sweep_rd_addr   in   AW       sweep read address (dft_idx)
//  disp_req        in   1        display burst request (level; sampled only in IDLE)
//  disp_start_idx  in   AW       first bin of burst
//  disp_len        in   AW+1     bins in burst; 0 or >FFT_SIZE means FFT_SIZE
//  disp_ack        out  1        1-cycle pulse: burst accepted, operands latched
//  disp_busy       out  1        high from ack until the cycle after the last data beat
//  disp_rd_valid   out  1        data beat valid
//  disp_rd_idx     out  AW       bin index of current beat
//  disp_rd_data    out  2*WW     bin value of current beat
//  disp_done       out  1        1-cycle pulse coincident with the last data beat
//  stall_cycles    out  16       cycles of the current/last burst lost to sweep (debug)
//  ram_rd_addr     out  AW       to FFT_RAM rd_addr
//  ram_rd_data     in   2*WW     from FFT_RAM rd_data
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; disp_ack, disp_busy, disp_rd_valid, disp_done = 0;
//   disp_rd_idx, disp_rd_data, stall_cycles = 0; in-flight reads discarded. Release is synchronous to clk.
//  Address mux (combinational): ram_rd_addr = sweep_active ? sweep_rd_addr : issue_addr.
//   With sweep_active=0 and no burst, ram_rd_addr = last issue_addr (no glitch requirement).
//  FSM: IDLE -> BURST -> DRAIN -> IDLE.
//   IDLE : disp_req=1 -> pulse disp_ack, latch start/len (len clamped), issue_addr=start,
//          remaining=len, clear stall_cycles, disp_busy=1, go BURST. Same-cycle sweep_active still accepts.
//   BURST: each cycle with sweep_active=0 -> issue read at issue_addr,
//          issue_addr = (issue_addr+1) mod FFT_SIZE, remaining-1; last issue -> DRAIN.
//          Cycle with sweep_active=1 -> no issue, stall_cycles +1 (saturate at 16'hFFFF).
//   DRAIN: wait for final beat to emerge; then IDLE, disp_busy=0 the following cycle.
//  Read pipeline: issue at cycle t -> RAM data at t+1 -> disp_rd_data/idx/valid registered at t+2.
//   Latency exactly 2 cycles from issue; valid beats carry consecutive indices (mod FFT_SIZE).
//   Sweep reads never produce display beats (tag bit tracks display issues only).
//  disp_req while busy: ignored, no ack; requester must drop/re-present after disp_busy falls.
//  Wrap-around: start 250, len 10 -> idx 250..255,0..3. Full frame: len 0 -> FFT_SIZE beats.
//  Coherency: no write blocking; a bin read during its own update returns the old or new value, never
//   mixed (RAM word-atomic). Frame-consistency is the display's problem.
//  Reset mid-burst: burst abandoned, no disp_done, outputs to reset values.
// TESTING
//  1. Idle sweep, req start=0 len=4 -> ack t0; valid beats idx 0,1,2,3 at t0+3..t0+6; done with idx 3; stall=0.
//  2. Wrap: start=254 len=4 -> beats idx 254,255,0,1; data match preloaded RAM pattern {idx,~idx}.
//  3. sweep_active high 3 cycles mid-burst of len 8 -> 8 beats, no gaps in idx sequence, stall_cycles=3;
//     ram_rd_addr equals sweep_rd_addr every sweep cycle.
//  4. len=0 -> exactly 256 beats, idx 0..255, single done pulse; second req during busy -> no ack.
//  5. Assert reset (low) 2 beats into len=16 burst -> all outputs 0 immediately, no done; new req after
//     release -> normal burst from start.
//  6. Sweep saturation: sweep_active held 70000 cycles during burst -> stall_cycles=16'hFFFF, burst completes.

Source files
------------

// File: rtl/stft_bin_read_arbiter.sv
// Shares the spectrum RAM read port between the DFT sweep (absolute priority, zero added latency)
// and a display burst reader that streams bins in the sweep's idle gaps.
module stft_bin_read_arbiter #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned FFT_SIZE   = 256,
  localparam int unsigned AW        = $clog2(FFT_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sweep_active,
  input  logic [AW-1:0]           sweep_rd_addr,
  input  logic                    disp_req,
  input  logic [AW-1:0]           disp_start_idx,
  input  logic [AW:0]             disp_len,
  output logic                    disp_ack,
  output logic                    disp_busy,
  output logic                    disp_rd_valid,
  output logic [AW-1:0]           disp_rd_idx,
  output logic [2*WORD_WIDTH-1:0] disp_rd_data,
  output logic                    disp_done,
  output logic [15:0]             stall_cycles,
  output logic [AW-1:0]           ram_rd_addr,
  input  logic [2*WORD_WIDTH-1:0] ram_rd_data
);

  localparam logic [AW:0] FullLen = (AW+1)'(FFT_SIZE);
  localparam logic [AW:0] OneLen  = (AW+1)'(1);

  typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           issue_addr_q, issue_addr_d;
  logic [AW:0]             remaining_q, remaining_d;
  logic [15:0]             stall_q, stall_d;
  logic                    accept;
  logic                    issue;
  logic [AW:0]             len_clamped;

  logic                    s1_valid_q, s1_last_q;
  logic [AW-1:0]           s1_idx_q;
  logic                    valid_q, done_q;
  logic [AW-1:0]           idx_q;
  logic [2*WORD_WIDTH-1:0] data_q;

  assign len_clamped = (disp_len == '0 || disp_len > FullLen) ? FullLen : disp_len;
  assign issue       = (state_q == StBurst) && !sweep_active;

  always_comb begin
    state_d      = state_q;
    issue_addr_d = issue_addr_q;
    remaining_d  = remaining_q;
    stall_d      = stall_q;
    accept       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (disp_req) begin
          accept       = 1'b1;
          issue_addr_d = disp_start_idx;
          remaining_d  = len_clamped;
          stall_d      = '0;
          state_d      = StBurst;
        end
      end
      StBurst: begin
        if (sweep_active) begin
          if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
        end else begin
          issue_addr_d = issue_addr_q + 1'b1;
          remaining_d  = remaining_q - OneLen;
          if (remaining_q == OneLen) state_d = StDrain;
        end
      end
      StDrain: begin
        // done_q marks the final beat on the output this cycle
        if (done_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      issue_addr_q <= '0;
      remaining_q  <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      issue_addr_q <= issue_addr_d;
      remaining_q  <= remaining_d;
      stall_q      <= stall_d;
    end
  end

  // Stage 1 tags display issues while the RAM read is in flight; stage 2 registers the beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
    end else begin
      s1_valid_q <= issue;
      s1_last_q  <= issue && (remaining_q == OneLen);
      if (issue) s1_idx_q <= issue_addr_q;
      valid_q <= s1_valid_q;
      done_q  <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        idx_q  <= s1_idx_q;
        data_q <= ram_rd_data;
      end
    end
  end

  // Ack is combinational so the first read issues the cycle after acceptance.
  assign disp_ack      = accept && reset;
  assign disp_busy     = (state_q != StIdle);
  assign disp_rd_valid = valid_q;
  assign disp_rd_idx   = idx_q;
  assign disp_rd_data  = data_q;
  assign disp_done     = done_q;
  assign stall_cycles  = stall_q;
  assign ram_rd_addr   = sweep_active ? sweep_rd_addr : issue_addr_q;

endmodule

// File: tb/tb_stft_bin_read_arbiter.sv
// Directed bench for stft_bin_read_arbiter: bursts, wrap, sweep stalls, full frame, reset, saturation.
module tb_stft_bin_read_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sweep_active = 1'b0;
  logic [7:0]  sweep_rd_addr = '0;
  logic        disp_req = 1'b0;
  logic [7:0]  disp_start_idx = '0;
  logic [8:0]  disp_len = '0;
  logic        disp_ack, disp_busy, disp_rd_valid, disp_done;
  logic [7:0]  disp_rd_idx;
  logic [31:0] disp_rd_data;
  logic [15:0] stall_cycles;
  logic [7:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;

  logic [31:0] mem [256];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          q_idx[$];
  logic [31:0] q_data[$];
  bit          q_done[$];
  int          q_cyc[$];

  stft_bin_read_arbiter #(.WORD_WIDTH(16), .FFT_SIZE(256)) dut (
    .clk(clk), .reset(reset), .sweep_active(sweep_active), .sweep_rd_addr(sweep_rd_addr),
    .disp_req(disp_req), .disp_start_idx(disp_start_idx), .disp_len(disp_len),
    .disp_ack(disp_ack), .disp_busy(disp_busy), .disp_rd_valid(disp_rd_valid),
    .disp_rd_idx(disp_rd_idx), .disp_rd_data(disp_rd_data), .disp_done(disp_done),
    .stall_cycles(stall_cycles), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {v, ~v};
  endfunction

  initial for (int i = 0; i < 256; i++) mem[i] = pat(i);

  always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && disp_rd_valid) begin
      q_idx.push_back(int'(disp_rd_idx));
      q_data.push_back(disp_rd_data);
      q_done.push_back(disp_done);
      q_cyc.push_back(cyc);
    end
    if (disp_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Issues one burst, optionally holding sweep_active over offsets [sw_from, sw_to] after the ack.
  task automatic run_burst(input string tag, input int start, input int len, input int exp_n,
                           input int sw_from, input int sw_to, input int exp_stall,
                           input bit poke);
    int base, dbase, ack_cyc, off, budget, n, first_off, bad, e;
    base   = q_idx.size();
    dbase  = done_cnt;
    budget = exp_n + ((sw_to >= sw_from) ? (sw_to - sw_from + 1) : 0) + 20;
    @(posedge clk); #1;
    disp_req = 1'b1; disp_start_idx = 8'(start); disp_len = 9'(len);
    #1;
    chk({tag, "_ack"}, disp_ack, 1);
    ack_cyc = cyc;
    @(posedge clk); #1;
    disp_req = 1'b0;
    chk({tag, "_busy"}, disp_busy, 1);
    off = 1;
    while (disp_busy && off < budget) begin
      sweep_active  = (off >= sw_from && off <= sw_to);
      sweep_rd_addr = 8'(off * 7 + 3);
      #1;
      if (sweep_active && off < sw_from + 4) chk({tag, "_sweep_addr"}, ram_rd_addr, sweep_rd_addr);
      if (poke && off == 20) begin
        disp_req = 1'b1; #1;
        chk({tag, "_busy_req_noack"}, disp_ack, 0);
        disp_req = 1'b0;
      end
      @(posedge clk); #1;
      off++;
    end
    sweep_active = 1'b0;
    chk({tag, "_busy_fell"}, disp_busy, 0);
    n = q_idx.size() - base;
    chk({tag, "_count"}, n, exp_n);
    bad = 0;
    for (int k = 0; k < n && k < exp_n; k++) begin
      e = (start + k) % 256;
      if (q_idx[base+k] != e || q_data[base+k] !== pat(e) || q_done[base+k] != (k == exp_n - 1))
        bad = bad + 1;
    end
    chk({tag, "_seq"}, bad, 0);
    chk({tag, "_done_pulses"}, done_cnt - dbase, 1);
    first_off = (sw_from == 1) ? sw_to + 1 : 1;
    if (n > 0) chk({tag, "_latency"}, q_cyc[base], ack_cyc + first_off + 2);
    chk({tag, "_stall"}, stall_cycles, exp_stall);
  endtask

  initial begin
    int base, dbase, n;
    #22;
    chk("reset_valid", disp_rd_valid, 0);
    chk("reset_busy", disp_busy, 0);
    chk("reset_done", disp_done, 0);
    chk("reset_stall", stall_cycles, 0);
    chk("reset_idx", disp_rd_idx, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_burst("t1", 0, 4, 4, 0, -1, 0, 1'b0);
    #1;
    chk("t1_idle_addr", ram_rd_addr, 4);
    run_burst("t2_wrap", 254, 4, 4, 0, -1, 0, 1'b0);
    run_burst("t2b_wrap", 250, 10, 10, 0, -1, 0, 1'b0);
    run_burst("t3_stall", 0, 8, 8, 3, 5, 3, 1'b0);
    run_burst("t4_full", 0, 0, 256, 0, -1, 0, 1'b1);
    run_burst("t4b_over", 7, 300, 256, 0, -1, 0, 1'b0);

    // Reset two beats into a 16-bin burst
    base  = q_idx.size();
    dbase = done_cnt;
    @(posedge clk); #1;
    disp_req = 1'b1; disp_start_idx = 8'd0; disp_len = 9'd16;
    #1;
    chk("t5_ack", disp_ack, 1);
    @(posedge clk); #1;
    disp_req = 1'b0;
    n = 0;
    while (q_idx.size() - base < 2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_two_beats", (q_idx.size() - base >= 2), 1);
    reset = 1'b0; disp_req = 1'b1;
    #1;
    chk("t5_rst_valid", disp_rd_valid, 0);
    chk("t5_rst_busy", disp_busy, 0);
    chk("t5_rst_done", disp_done, 0);
    chk("t5_rst_ack", disp_ack, 0);
    chk("t5_rst_idx", disp_rd_idx, 0);
    chk("t5_rst_data", disp_rd_data, 0);
    chk("t5_rst_stall", stall_cycles, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt - dbase, 0);
    disp_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    run_burst("t5_after", 0, 16, 16, 0, -1, 0, 1'b0);

    run_burst("t6_sat", 20, 4, 4, 1, 70000, 16'hFFFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
